// File: rtl/div_iter_if.sv
// Request/result bundle for the iterative divider.
// The master side is the execute-stage ALU, the slave side is the divider.
interface div_iter_if;
    logic        div_valid;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_ready;
    logic        cancel;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    modport master (
        output div_valid, div_signed, dividend, divisor, cancel, dout_ready,
        input  div_ready, dout_valid, quotient, remainder
    );

    modport slave (
        input  div_valid, div_signed, dividend, divisor, cancel, dout_ready,
        output div_ready, dout_valid, quotient, remainder
    );
endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, 32-bit signed/unsigned.
// A request is accepted in IDLE, 32 BUSY cycles produce one quotient bit
// each on the magnitudes, FIX applies signs and the divide-by-zero result,
// and DONE holds the result until the consumer takes it.
module div_iter (
    input  logic      clk,
    input  logic      resetn,
    div_iter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] quo_shift;
    logic [31:0] rem_reg;
    logic [31:0] divisor_abs;
    logic [31:0] dividend_orig;
    logic [4:0]  bit_count;
    logic        q_neg;
    logic        r_neg;
    logic        div_zero;

    logic        dout_valid_reg;
    logic [31:0] quotient_reg;
    logic [31:0] remainder_reg;

    logic [31:0] dividend_abs;
    logic [31:0] divisor_in_abs;
    logic [32:0] partial;
    logic [32:0] diff;
    logic        diff_neg;
    logic [31:0] quotient_fix;
    logic [31:0] remainder_fix;

    assign bus.div_ready  = (state == IDLE);
    assign bus.dout_valid = dout_valid_reg;
    assign bus.quotient   = quotient_reg;
    assign bus.remainder  = remainder_reg;

    // Operand magnitudes at acceptance; only signed requests take the absolute value.
    always_comb begin
        dividend_abs   = bus.dividend;
        divisor_in_abs = bus.divisor;
        if (bus.div_signed && bus.dividend[31]) begin
            dividend_abs = ~bus.dividend + 32'd1;
        end
        if (bus.div_signed && bus.divisor[31]) begin
            divisor_in_abs = ~bus.divisor + 32'd1;
        end
    end

    // One restoring step: trial-subtract the divisor from the shifted partial remainder.
    always_comb begin
        partial  = {rem_reg, quo_shift[31]};
        diff     = partial - {1'b0, divisor_abs};
        diff_neg = diff[32];
    end

    // Final sign correction, with divide-by-zero overriding the iterated result.
    always_comb begin
        quotient_fix  = q_neg ? (~quo_shift + 32'd1) : quo_shift;
        remainder_fix = r_neg ? (~rem_reg + 32'd1) : rem_reg;
        if (div_zero) begin
            quotient_fix  = 32'hFFFF_FFFF;
            remainder_fix = dividend_orig;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; cancel returns to IDLE from anywhere and beats a new request.
    always_comb begin
        state_next = state;
        if (bus.cancel) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.div_valid) begin
                        state_next = BUSY;
                    end
                end
                BUSY: begin
                    if (bit_count == 5'd0) begin
                        state_next = FIX;
                    end
                end
                FIX: begin
                    state_next = DONE;
                end
                DONE: begin
                    if (dout_valid_reg && bus.dout_ready) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Datapath: latch operands, iterate, publish the result and hold it until taken.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            quo_shift      <= 32'd0;
            rem_reg        <= 32'd0;
            divisor_abs    <= 32'd0;
            dividend_orig  <= 32'd0;
            bit_count      <= 5'd0;
            q_neg          <= 1'b0;
            r_neg          <= 1'b0;
            div_zero       <= 1'b0;
            dout_valid_reg <= 1'b0;
            quotient_reg   <= 32'd0;
            remainder_reg  <= 32'd0;
        end else if (bus.cancel) begin
            dout_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.div_valid) begin
                        quo_shift     <= dividend_abs;
                        rem_reg       <= 32'd0;
                        divisor_abs   <= divisor_in_abs;
                        dividend_orig <= bus.dividend;
                        q_neg         <= bus.div_signed & (bus.dividend[31] ^ bus.divisor[31]);
                        r_neg         <= bus.div_signed & bus.dividend[31];
                        div_zero      <= (bus.divisor == 32'd0);
                        bit_count     <= 5'd31;
                    end
                end
                BUSY: begin
                    if (diff_neg) begin
                        rem_reg   <= partial[31:0];
                        quo_shift <= {quo_shift[30:0], 1'b0};
                    end else begin
                        rem_reg   <= diff[31:0];
                        quo_shift <= {quo_shift[30:0], 1'b1};
                    end
                    if (bit_count != 5'd0) begin
                        bit_count <= bit_count - 5'd1;
                    end
                end
                FIX: begin
                    quotient_reg   <= quotient_fix;
                    remainder_reg  <= remainder_fix;
                    dout_valid_reg <= 1'b1;
                end
                DONE: begin
                    if (dout_valid_reg && bus.dout_ready) begin
                        dout_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    dout_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule
